// File: rtl/us_tick_timer.sv
// us_tick_timer: programmable microsecond delay timer.
// Counts a requested number of single-cycle tick strobes from the upstream
// microsecond tick counter. It reports busy and the remaining tick count, and
// pulses done for one clk when the delay has elapsed.
// Optional feature: define TIMER_AUTO_RELOAD_EN to make a running delay repeat
// every N ticks, with a done pulse each period, until it is aborted.
// All outputs are registered.
module us_tick_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] load_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] remain_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic             last_tick;

`ifdef TIMER_AUTO_RELOAD_EN
   logic [CNT_W-1:0] reload_q, reload_d;
`endif

   // A tick that arrives when one tick is left ends the current period.
   assign last_tick = (remain_q <= CNT_W'(1));

   // Next state, next count and next registered outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case statement. A path
      // that leaves a combinational output unassigned would infer a latch.
      state_d  = state_q;
      remain_d = remain_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_d = reload_q;
`endif
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            // When start and abort arrive together, the start is dropped.
            if (start_i && !abort_i) begin
               if (load_i != '0) begin
                  state_d  = RUN;
                  remain_d = load_i;
                  busy_d   = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                  reload_d = load_i;
`endif
               end else begin
                  // A zero-length delay still produces its done pulse.
                  state_d  = DONE;
                  remain_d = '0;
                  done_d   = 1'b1;
               end
            end
         end
         RUN: begin
            busy_d = 1'b1;
            if (abort_i) begin
               // Abort wins over a coincident tick, and no done pulse follows.
               state_d  = IDLE;
               remain_d = '0;
               busy_d   = 1'b0;
            end else if (tick_i) begin
               if (last_tick) begin
`ifdef TIMER_AUTO_RELOAD_EN
                  remain_d = reload_q;
                  done_d   = 1'b1;
`else
                  state_d  = DONE;
                  remain_d = '0;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
`endif
               end else begin
                  remain_d = remain_q - CNT_W'(1);
               end
            end
         end
         DONE: begin
            // The done pulse lasts one clk. Start, abort and tick are ignored.
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d  = IDLE;
            remain_d = '0;
            busy_d   = 1'b0;
         end
      endcase
   end

   // State and output registers. Reset forces IDLE with all outputs low.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so that
      // every flop samples values from before the edge.
      if (!rst_n) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         remain_q <= '0;
`ifdef TIMER_AUTO_RELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         remain_q <= remain_d;
`ifdef TIMER_AUTO_RELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign remain_o = remain_q;

endmodule

// File: tb/tb_us_tick_timer.sv
// Directed testbench for us_tick_timer. Expected values are hand-computed.
// Ticks arrive every 20 clk. Inputs are driven and outputs sampled 1 ns after
// each rising edge.
module tb_us_tick_timer;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             tick_i = 1'b0;
   logic             start_i = 1'b0;
   logic [CNT_W-1:0] load_i = '0;
   logic             abort_i = 1'b0;
   logic             busy_o;
   logic             done_o;
   logic [CNT_W-1:0] remain_o;

   int n_checks = 0;
   int n_pass   = 0;
   logic done_seen = 1'b0;

   us_tick_timer #(.CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick_i),
      .start_i  (start_i),
      .load_i   (load_i),
      .abort_i  (abort_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .remain_o (remain_o)
   );

   // 20 MHz clock.
   always #25 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Run n cycles without a tick, and record any done pulse.
   task automatic run_idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         done_seen = done_seen | done_o;
      end
   endtask

   // Wait 19 quiet cycles, then drive one tick cycle.
   task automatic send_tick();
      run_idle(19);
      tick_i = 1'b1;
      step();
      tick_i = 1'b0;
      done_seen = done_seen | done_o;
   endtask

   task automatic start(input logic [CNT_W-1:0] val);
      start_i = 1'b1;
      load_i  = val;
      step();
      start_i = 1'b0;
   endtask

   initial begin
      // Reset values.
      step();
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_remain", remain_o, 0);
      rst_n = 1'b1;
      run_idle(2);

      // Zero load: done at E+1, busy never high.
      start(16'd0);
      check("zero_done", done_o, 1);
      check("zero_busy", busy_o, 0);
      step();
      check("zero_done_end", done_o, 0);
      check("zero_busy_after", busy_o, 0);
      run_idle(2);

`ifndef TIMER_AUTO_RELOAD_EN
      // One-shot, load 3.
      start(16'd3);
      check("os_busy_start", busy_o, 1);
      check("os_remain_start", remain_o, 3);
      done_seen = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         send_tick();
         check("os_remain", remain_o, 32'(3 - k));
         check("os_busy_run", busy_o, 1);
      end
      check("os_no_early_done", done_seen, 0);
      send_tick();
      check("os_done", done_o, 1);
      check("os_busy_at_done", busy_o, 0);
      check("os_remain_end", remain_o, 0);
      step();
      check("os_done_1clk", done_o, 0);
      check("os_busy_after", busy_o, 0);
      run_idle(3);

      // Coincident tick and start: that tick is not counted.
      start_i = 1'b1;
      load_i  = 16'd2;
      tick_i  = 1'b1;
      step();
      start_i = 1'b0;
      tick_i  = 1'b0;
      check("co_remain_start", remain_o, 2);
      send_tick();
      check("co_remain_1", remain_o, 1);
      check("co_no_done", done_o, 0);
      send_tick();
      check("co_done", done_o, 1);
      run_idle(3);

      // Restart while running is ignored.
      start(16'd4);
      start(16'd9);
      check("rs_remain_kept", remain_o, 4);
      for (int k = 0; k < 3; k++) send_tick();
      check("rs_remain_1", remain_o, 1);
      send_tick();
      check("rs_done_after_4", done_o, 1);
      // A start sampled in DONE is ignored too.
      start(16'd7);
      check("rs_start_in_done_busy", busy_o, 0);
      check("rs_start_in_done_rem", remain_o, 0);
      // The first start that can be accepted is sampled in IDLE.
      start(16'd6);
      check("rs_start_idle_busy", busy_o, 1);
      check("rs_start_idle_rem", remain_o, 6);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      run_idle(2);
`else
      // Auto reload, load 2: a done pulse every 2 ticks while busy stays high.
      start(16'd2);
      check("ar_busy_start", busy_o, 1);
      for (int k = 1; k <= 6; k++) begin
         send_tick();
         check("ar_done", done_o, 32'((k % 2) == 0));
         check("ar_busy", busy_o, 1);
         check("ar_remain", remain_o, ((k % 2) == 0) ? 32'd2 : 32'd1);
      end
      step();
      check("ar_done_1clk", done_o, 0);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      check("ar_abort_busy", busy_o, 0);
      done_seen = 1'b0;
      for (int k = 0; k < 4; k++) send_tick();
      check("ar_no_done_after_abort", done_seen, 0);
      run_idle(2);
`endif

      // Abort together with the 4th tick.
      start(16'd10);
      done_seen = 1'b0;
      for (int k = 0; k < 3; k++) send_tick();
      check("ab_remain_7", remain_o, 7);
      run_idle(19);
      tick_i  = 1'b1;
      abort_i = 1'b1;
      step();
      tick_i  = 1'b0;
      abort_i = 1'b0;
      check("ab_busy", busy_o, 0);
      check("ab_remain", remain_o, 0);
      check("ab_done", done_o, 0);
      for (int k = 0; k < 4; k++) send_tick();
      check("ab_no_done_ever", done_seen, 0);
      check("ab_busy_after", busy_o, 0);

      // Reset in the middle of a run, asserted between clock edges.
      start(16'd5);
      send_tick();
      send_tick();
      check("rr_remain_3", remain_o, 3);
      #5;
      rst_n = 1'b0;
      #1;
      check("rr_busy_async", busy_o, 0);
      check("rr_done_async", done_o, 0);
      check("rr_remain_async", remain_o, 0);
      step();
      rst_n = 1'b1;
      done_seen = 1'b0;
      for (int k = 0; k < 4; k++) send_tick();
      check("rr_no_done", done_seen, 0);
      check("rr_busy_after", busy_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
